// File: rtl/perf_counter_unit_pkg.sv
// Shared types for the performance counter unit: instruction classes and
// the per-stage tracking record carried down the shadow pipeline.
package perf_pkg;

    localparam int CNT_W = 19;

    typedef enum logic [1:0] {
        CLS_OTHER  = 2'd0,
        CLS_ARITH  = 2'd1,
        CLS_MEM    = 2'd2,
        CLS_BRANCH = 2'd3
    } inst_class_t;

    typedef struct packed {
        logic        valid;
        inst_class_t cls;
    } stage_t;

endpackage

// File: rtl/perf_counter_unit_sat_counter.sv
// Saturating up-counter: counts when inc is set and hold is clear, and sticks
// at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             hold,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && !hold && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/perf_counter_unit.sv
// Shadow pipeline that follows instructions from issue to retire and feeds
// saturating stall / arithmetic / memory / total-retired counters.
module perf_counter_unit
    import perf_pkg::*;
#(
    parameter int PIPE_DEPTH   = 4,
    parameter int FLUSH_STAGES = 2,
    parameter int CNT_W        = perf_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [1:0]       issue_class,
    input  logic             stall,
    input  logic             flush,
    input  logic             finish,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] aritmetric_count,
    output logic [CNT_W-1:0] memory_count,
    output logic [CNT_W-1:0] instruction_count,
    output logic [2:0]       inflight
);

    stage_t     stage_q [PIPE_DEPTH];
    stage_t     stage_d [PIPE_DEPTH];
    logic [2:0] inflight_q;
    logic [2:0] inflight_d;
    logic       retire;
    logic       retire_arith;
    logic       retire_mem;

    // Retire only happens on a shifting cycle; the oldest stage is never
    // touched by flush, so an instruction leaving during a flush still counts.
    always_comb begin
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        retire = 1'b0;
        if (!stall) begin
            retire        = stage_q[PIPE_DEPTH-1].valid;
            stage_d[0]    = '{valid: issue_valid, cls: inst_class_t'(issue_class)};
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
        if (flush) begin
            for (int i = 0; i < FLUSH_STAGES; i++) begin
                stage_d[i].valid = 1'b0;
            end
        end
    end

    assign retire_arith = retire && (stage_q[PIPE_DEPTH-1].cls == CLS_ARITH);
    assign retire_mem   = retire && (stage_q[PIPE_DEPTH-1].cls == CLS_MEM);

    always_comb begin
        inflight_d = 3'd0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            inflight_d = inflight_d + {2'b00, stage_d[i].valid};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                stage_q[i] <= '{valid: 1'b0, cls: CLS_OTHER};
            end
            inflight_q <= 3'd0;
        end else begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
            inflight_q <= inflight_d;
        end
    end

    assign inflight = inflight_q;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall),
        .hold  (finish),
        .count (stall_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_arith_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire_arith),
        .hold  (finish),
        .count (aritmetric_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_mem_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire_mem),
        .hold  (finish),
        .count (memory_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_instr_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire),
        .hold  (finish),
        .count (instruction_count)
    );

endmodule
